// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM encoding, default width and
// the quotient returned when dividing by zero.
package div_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam logic [DEFAULT_DATA_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negation, purely combinational.
// Used both to take operand magnitudes and to restore result signs.
module cond_negate #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] in_dat,
  input  logic                  neg,
  output logic [DATA_WIDTH-1:0] out_dat
);

  assign out_dat = neg ? (~in_dat + 1'b1) : in_dat;

endmodule

// File: rtl/iterative_divider.sv
// Restoring divider, one quotient bit per cycle: DATA_WIDTH+1 cycles start-to-done
// (1 cycle for a zero divisor). start is only accepted while idle; busy stalls the pipe.
module iterative_divider
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);

  localparam int MSB   = DATA_WIDTH - 1;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic                  quo_neg_q, quo_neg_d;
  logic                  rem_neg_q, rem_neg_d;
  logic                  zero_q, zero_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
  logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
  logic                  div_by_zero_q, div_by_zero_d;

  logic [DATA_WIDTH-1:0] dvd_mag, dvs_mag, quo_fix, rem_fix;

  cond_negate #(.DATA_WIDTH(DATA_WIDTH)) u_neg_dvd (
    .in_dat (dividend),
    .neg    (is_signed & dividend[MSB]),
    .out_dat(dvd_mag)
  );

  cond_negate #(.DATA_WIDTH(DATA_WIDTH)) u_neg_dvs (
    .in_dat (divisor),
    .neg    (is_signed & divisor[MSB]),
    .out_dat(dvs_mag)
  );

  cond_negate #(.DATA_WIDTH(DATA_WIDTH)) u_fix_quo (
    .in_dat (quo_q),
    .neg    (quo_neg_q),
    .out_dat(quo_fix)
  );

  cond_negate #(.DATA_WIDTH(DATA_WIDTH)) u_fix_rem (
    .in_dat (rem_q),
    .neg    (rem_neg_q),
    .out_dat(rem_fix)
  );

  // The shifted partial remainder can reach 2*divisor-1, so it needs one extra bit;
  // when it fits the divisor the difference always fits back into DATA_WIDTH bits.
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH-1:0] trial;
  logic                  fits;

  assign shifted = {rem_q, quo_q[MSB]};
  assign trial   = shifted[MSB:0] - dvs_q;
  assign fits    = (shifted >= {1'b0, dvs_q});

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    quo_neg_d     = quo_neg_q;
    rem_neg_d     = rem_neg_q;
    zero_d        = zero_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          quo_neg_d = is_signed & (dividend[MSB] ^ divisor[MSB]);
          rem_neg_d = is_signed & dividend[MSB];
          dvs_d     = dvs_mag;
          rem_d     = '0;
          cnt_d     = '0;
          // On a zero divisor quo holds the raw dividend, which becomes the remainder.
          if (divisor == '0) begin
            zero_d  = 1'b1;
            quo_d   = dividend;
            state_d = FIX;
          end else begin
            zero_d  = 1'b0;
            quo_d   = dvd_mag;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = fits ? trial : shifted[MSB:0];
        quo_d = {quo_q[MSB-1:0], fits};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (zero_q) begin
          quotient_d    = {DATA_WIDTH{DIV_ZERO_QUOTIENT[0]}};
          remainder_d   = quo_q;
          div_by_zero_d = 1'b1;
        end else begin
          quotient_d    = quo_fix;
          remainder_d   = rem_fix;
          div_by_zero_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      quo_neg_q     <= 1'b0;
      rem_neg_q     <= 1'b0;
      zero_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dvs_q         <= dvs_d;
      quo_neg_q     <= quo_neg_d;
      rem_neg_q     <= rem_neg_d;
      zero_q        <= zero_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_iterative_divider.sv
// Scoreboard bench for iterative_divider: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_iterative_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  iterative_divider #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          chk("busy_with_done", {31'b0, busy}, 32'd0);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1, expected no pending operation (t=%0t)", $time);
          end else begin
            e = sb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.z});
            chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
            chk("busy_cycles", 32'(busy_cnt), 32'(e.lat));
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // Called at a negedge (typically the done cycle of the previous op, so every
  // operation also exercises back-to-back start); returns at the negedge of its done cycle.
  task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input logic z,
                        input int ign_at);
    exp_t e;
    bit   got;
    start     = 1'b1;
    is_signed = sg;
    dividend  = a;
    divisor   = b;
    e.q = q;
    e.r = r;
    e.z = z;
    e.lat = z ? 1 : 33;
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    chk("busy_rise", {31'b0, busy}, 32'd1);
    got = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == ign_at) begin
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = 32'd999;
        divisor   = 32'd4;
      end else begin
        start    = 1'b0;
        dividend = $urandom();
        divisor  = $urandom();
      end
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done in 100 cycles, expected done for 0x%08h/0x%08h", a, b);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        1'b0, 0);
    run_op(1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,       1'b0, 0);
    run_op(1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,      32'hFFFF_FFFE, 1'b0, 0);
    run_op(1'b0, 32'h1234_5678,  32'd0,        32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 0);
    run_op(1'b1, 32'h1234_5678,  32'd0,        32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 0);
    run_op(1'b1, 32'h8000_0001,  32'd0,        32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 0);
    run_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       1'b0, 0);
    run_op(1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0,        1'b0, 0);
    run_op(1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,       32'h8000_0000, 1'b0, 0);
    run_op(1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        1'b0, 5);
    run_op(1'b0, 32'hFFFF_FFFF,  32'h8000_0000, 32'd1,       32'h7FFF_FFFF, 1'b0, 0);

    // Abort an operation with reset part-way through RUN; nothing is expected from it.
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    chk("midrst_dbz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    run_op(1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
